// File: rtl/instr_cache_line.sv
// Direct-mapped instruction cache with multi-word lines, in-order burst refill and a
// single-cycle global invalidate.
module instr_cache_line #(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cache_flush,
   output logic        stall,
   input  logic        inst_sram_en,
   input  logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_rdata,
   output logic        inst_cache_req,
   output logic [31:0] inst_cache_addr,
   input  logic [31:0] inst_cache_rdata,
   input  logic        inst_cache_dok
);

   localparam int unsigned OFF_W = $clog2(LINE_WORDS);
   localparam int unsigned TAG_W = 32 - INDEX_BITS - OFF_W - 2;
   localparam int unsigned LINES = 2 ** INDEX_BITS;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [0:0] {StIdle, StRefill} state_e;

   state_e           state_q;
   logic [OFF_W-1:0] cnt_q;
   logic             kill_q;
   logic             req_q;
   logic [31:0]      base_q;
   logic [LINES-1:0] valid_q;

   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES*LINE_WORDS];

   logic [TAG_W-1:0]      addr_tag;
   logic [INDEX_BITS-1:0] addr_idx;
   logic [OFF_W-1:0]      addr_off;
   logic [TAG_W-1:0]      ref_tag;
   logic [INDEX_BITS-1:0] ref_idx;
   logic                  lookup_ok;
   logic                  hit;
   logic                  miss;
   logic                  beat;
   logic                  last_beat;

   assign addr_tag = inst_sram_addr[31 -: TAG_W];
   assign addr_idx = inst_sram_addr[2+OFF_W +: INDEX_BITS];
   assign addr_off = inst_sram_addr[2 +: OFF_W];
   assign ref_tag  = base_q[31 -: TAG_W];
   assign ref_idx  = base_q[2+OFF_W +: INDEX_BITS];

   // resetn gates the lookup so stall and rdata drop together with the FSM during reset.
   assign lookup_ok = resetn && (state_q == StIdle) && inst_sram_en
                      && (inst_sram_addr[1:0] == 2'b00);
   assign hit       = valid_q[addr_idx] && (tag_mem[addr_idx] == addr_tag);
   assign miss      = lookup_ok && !hit;
   assign beat      = (state_q == StRefill) && inst_cache_dok;
   assign last_beat = beat && (cnt_q == LAST_BEAT);

   assign stall           = (resetn && (state_q == StRefill)) || miss;
   assign inst_sram_rdata = (lookup_ok && hit) ? data_mem[{addr_idx, addr_off}] : 32'h0;
   assign inst_cache_req  = req_q;
   assign inst_cache_addr = base_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         kill_q  <= 1'b0;
         req_q   <= 1'b0;
         base_q  <= 32'h0;
         valid_q <= '0;
      end else begin
         if (cache_flush) valid_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (miss) begin
                  state_q <= StRefill;
                  req_q   <= 1'b1;
                  base_q  <= {inst_sram_addr[31:2+OFF_W], (OFF_W+2)'(0)};
                  cnt_q   <= '0;
                  kill_q  <= 1'b0;
               end
            end
            StRefill: begin
               if (cache_flush) kill_q <= 1'b1;
               if (inst_cache_dok) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST_BEAT) begin
                     // A flush seen at any point during the burst leaves the line invalid.
                     valid_q[ref_idx] <= !(kill_q || cache_flush);
                     state_q <= StIdle;
                     req_q   <= 1'b0;
                     base_q  <= 32'h0;
                     kill_q  <= 1'b0;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Storage arrays carry no reset; valid_q alone qualifies their contents.
   always_ff @(posedge clk) begin
      if (beat) data_mem[{ref_idx, cnt_q}] <= inst_cache_rdata;
      if (last_beat) tag_mem[ref_idx] <= ref_tag;
   end

endmodule

// File: tb/tb_instr_cache_line.sv
// Directed bench for instr_cache_line: refill, hits, conflict, flush, misalignment, reset.
module tb_instr_cache_line;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cache_flush;
   logic        stall;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        inst_cache_req;
   logic [31:0] inst_cache_addr;
   logic [31:0] inst_cache_rdata;
   logic        inst_cache_dok;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001;
   localparam logic [31:0] A2 = 32'hA000_0002, A3 = 32'hA000_0003;
   localparam logic [31:0] B0 = 32'hB000_0000, B1 = 32'hB000_0001;
   localparam logic [31:0] B2 = 32'hB000_0002, B3 = 32'hB000_0003;

   instr_cache_line #(.LINE_WORDS(4), .INDEX_BITS(6)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .cache_flush      (cache_flush),
      .stall            (stall),
      .inst_sram_en     (inst_sram_en),
      .inst_sram_addr   (inst_sram_addr),
      .inst_sram_rdata  (inst_sram_rdata),
      .inst_cache_req   (inst_cache_req),
      .inst_cache_addr  (inst_cache_addr),
      .inst_cache_rdata (inst_cache_rdata),
      .inst_cache_dok   (inst_cache_dok)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   // Presents one refill beat for one clock; inputs change only at negedge.
   task automatic give_beat(input logic [31:0] d, input logic fl);
      inst_cache_dok   = 1'b1;
      inst_cache_rdata = d;
      cache_flush      = fl;
      @(negedge clk);
      inst_cache_dok   = 1'b0;
      cache_flush      = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0; cache_flush = 1'b0; inst_sram_en = 1'b0; inst_sram_addr = 32'h0;
      inst_cache_rdata = 32'h0; inst_cache_dok = 1'b0;
      #3;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
      checks++; if (inst_cache_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", inst_cache_req); end
      checks++; if (inst_cache_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", inst_cache_addr); end
      checks++; if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", inst_sram_rdata); end
      @(negedge clk); @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_cold_miss;
      inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_1008;
      #2;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cold_stall_now: got %b want 1", stall); end
      @(negedge clk); #2;
      checks++; if (inst_cache_req !== 1'b1) begin errors++; $display("FAIL cold_req: got %b want 1", inst_cache_req); end
      checks++; if (inst_cache_addr !== 32'h0000_1000) begin errors++; $display("FAIL cold_addr: got %h want 00001000", inst_cache_addr); end
      give_beat(A0, 1'b0); give_beat(A1, 1'b0);
      inst_sram_addr = 32'h0000_3004;  // ignored during refill
      #2;
      checks++; if (inst_cache_addr !== 32'h0000_1000) begin errors++; $display("FAIL cold_addr_held: got %h want 00001000", inst_cache_addr); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cold_stall_mid: got %b want 1", stall); end
      inst_sram_addr = 32'h0000_1008;
      give_beat(A2, 1'b0); give_beat(A3, 1'b0);
      #2;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cold_stall_done: got %b want 0", stall); end
      checks++; if (inst_sram_rdata !== A2) begin errors++; $display("FAIL cold_rdata: got %h want %h", inst_sram_rdata, A2); end
      checks++; if (inst_cache_req !== 1'b0) begin errors++; $display("FAIL cold_req_drop: got %b want 0", inst_cache_req); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] addrs [3];
      logic [31:0] exp   [3];
      addrs[0] = 32'h0000_1000; addrs[1] = 32'h0000_1004; addrs[2] = 32'h0000_100C;
      exp[0] = A0; exp[1] = A1; exp[2] = A3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         inst_sram_addr = addrs[i];
         #2;
         checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall[%0d]: got %b want 0", i, stall); end
         checks++; if (inst_sram_rdata !== exp[i]) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, inst_sram_rdata, exp[i]); end
         checks++; if (inst_cache_req !== 1'b0) begin errors++; $display("FAIL b2b_req[%0d]: got %b want 0", i, inst_cache_req); end
      end
   endtask

   task automatic test_conflict;
      @(negedge clk);
      inst_sram_addr = 32'h0000_2008;
      #2;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL conf_stall: got %b want 1", stall); end
      @(negedge clk); #2;
      checks++; if (inst_cache_addr !== 32'h0000_2000) begin errors++; $display("FAIL conf_addr: got %h want 00002000", inst_cache_addr); end
      give_beat(B0, 1'b0); give_beat(B1, 1'b0); give_beat(B2, 1'b0); give_beat(B3, 1'b0);
      #2;
      checks++; if (inst_sram_rdata !== B2) begin errors++; $display("FAIL conf_rdata: got %h want %h", inst_sram_rdata, B2); end
      inst_sram_addr = 32'h0000_1008;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL conf_evict_stall: got %b want 1", stall); end
      @(negedge clk); #2;
      checks++; if (inst_cache_addr !== 32'h0000_1000) begin errors++; $display("FAIL conf_readdr: got %h want 00001000", inst_cache_addr); end
      give_beat(A0, 1'b0); give_beat(A1, 1'b0); give_beat(A2, 1'b0); give_beat(A3, 1'b0);
      #2;
      checks++; if (inst_sram_rdata !== A2) begin errors++; $display("FAIL conf_rdata2: got %h want %h", inst_sram_rdata, A2); end
   endtask

   task automatic test_flush;
      @(negedge clk);
      inst_sram_addr = 32'h0000_1004; cache_flush = 1'b1;
      #2;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_hit_stall: got %b want 0", stall); end
      checks++; if (inst_sram_rdata !== A1) begin errors++; $display("FAIL flush_hit_rdata: got %h want %h", inst_sram_rdata, A1); end
      @(negedge clk);
      cache_flush = 1'b0;
      #2;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_after_miss: got %b want 1", stall); end
      @(negedge clk);
      give_beat(A0, 1'b0); give_beat(A1, 1'b0); give_beat(A2, 1'b1); give_beat(A3, 1'b0);
      #2;
      // Line in flight completed invalid: the re-lookup misses again.
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_kill_stall: got %b want 1", stall); end
      checks++; if (inst_cache_req !== 1'b0) begin errors++; $display("FAIL flush_req_gap: got %b want 0", inst_cache_req); end
      @(negedge clk); #2;
      checks++; if (inst_cache_req !== 1'b1) begin errors++; $display("FAIL flush_rereq: got %b want 1", inst_cache_req); end
      checks++; if (inst_cache_addr !== 32'h0000_1000) begin errors++; $display("FAIL flush_readdr: got %h want 00001000", inst_cache_addr); end
      give_beat(A0, 1'b0); give_beat(A1, 1'b0); give_beat(A2, 1'b0); give_beat(A3, 1'b0);
      #2;
      checks++; if (inst_sram_rdata !== A1) begin errors++; $display("FAIL flush_refill_rdata: got %h want %h", inst_sram_rdata, A1); end
   endtask

   task automatic test_misaligned;
      inst_sram_addr = 32'h0000_1002;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL misal_stall: got %b want 0", stall); end
      checks++; if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL misal_rdata: got %h want 0", inst_sram_rdata); end
      @(negedge clk); #2;
      checks++; if (inst_cache_req !== 1'b0) begin errors++; $display("FAIL misal_req: got %b want 0", inst_cache_req); end
      inst_sram_en = 1'b0; inst_sram_addr = 32'h0000_3008;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL noen_stall: got %b want 0", stall); end
      @(negedge clk); #2;
      checks++; if (inst_cache_req !== 1'b0) begin errors++; $display("FAIL noen_req: got %b want 0", inst_cache_req); end
      inst_sram_addr = 32'h0000_1004;
      #1;
      checks++; if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL noen_rdata: got %h want 0", inst_sram_rdata); end
   endtask

   task automatic test_idle_dok;
      @(negedge clk);
      inst_sram_addr = 32'h0000_1000;
      give_beat(32'hDEAD_BEEF, 1'b0);
      inst_sram_en = 1'b1;
      #2;
      checks++; if (inst_sram_rdata !== A0) begin errors++; $display("FAIL idle_dok_rdata: got %h want %h", inst_sram_rdata, A0); end
      checks++; if (inst_cache_req !== 1'b0) begin errors++; $display("FAIL idle_dok_req: got %b want 0", inst_cache_req); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      inst_sram_addr = 32'h0000_2000;
      @(negedge clk);
      give_beat(B0, 1'b0); give_beat(B1, 1'b0);
      resetn = 1'b0;
      #1;
      checks++; if (inst_cache_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b want 0", inst_cache_req); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", stall); end
      checks++; if (inst_cache_addr !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h want 0", inst_cache_addr); end
      @(negedge clk);
      resetn = 1'b1; inst_sram_addr = 32'h0000_1000;
      #2;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstmid_remiss: got %b want 1", stall); end
      @(negedge clk); #2;
      checks++; if (inst_cache_addr !== 32'h0000_1000) begin errors++; $display("FAIL rstmid_readdr: got %h want 00001000", inst_cache_addr); end
   endtask

   initial begin
      test_reset;
      test_cold_miss;
      test_back_to_back;
      test_conflict;
      test_flush;
      test_misaligned;
      test_idle_dok;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
